// File: rtl/qea_host_sequencer_if.sv
// Bus bundle between the host sequencer and the QEA core: ctx stream in, CTX/STATE RAM ports,
// start/complete handshake and the result stream out. master = sequencer side.
interface qea_host_sequencer_if #(
  parameter int PE_NUM                  = 4,
  parameter int STATE_DATA_WIDTH        = 64,
  parameter int STATE_ADDR_WIDTH        = 16,
  parameter int GATE_CONTEXT_DATA_WIDTH = 64,
  parameter int GATE_CONTEXT_ADDR_WIDTH = 16
);
  localparam int SW = PE_NUM * STATE_DATA_WIDTH;

  logic                               s_ctx_valid;
  logic                               s_ctx_ready;
  logic [GATE_CONTEXT_DATA_WIDTH-1:0] s_ctx_data;

  logic                               o_ctx_en;
  logic                               o_ctx_wea;
  logic [GATE_CONTEXT_ADDR_WIDTH-1:0] o_ctx_addr;
  logic [GATE_CONTEXT_DATA_WIDTH-1:0] o_ctx_data;

  logic                               o_state_ena;
  logic                               o_state_wea;
  logic [STATE_ADDR_WIDTH-1:0]        o_state_addra;
  logic [SW-1:0]                      o_state_dina;
  logic [SW-1:0]                      i_state_dout;

  logic                               o_start;
  logic                               i_complete;

  logic                               m_res_valid;
  logic                               m_res_ready;
  logic [SW-1:0]                      m_res_data;
  logic                               m_res_last;

  modport master (
    input  s_ctx_valid, s_ctx_data, i_state_dout, i_complete, m_res_ready,
    output s_ctx_ready, o_ctx_en, o_ctx_wea, o_ctx_addr, o_ctx_data,
           o_state_ena, o_state_wea, o_state_addra, o_state_dina,
           o_start, m_res_valid, m_res_data, m_res_last
  );

  modport slave (
    output s_ctx_valid, s_ctx_data, i_state_dout, i_complete, m_res_ready,
    input  s_ctx_ready, o_ctx_en, o_ctx_wea, o_ctx_addr, o_ctx_data,
           o_state_ena, o_state_wea, o_state_addra, o_state_dina,
           o_start, m_res_valid, m_res_data, m_res_last
  );
endinterface

// File: rtl/qea_host_sequencer.sv
// Host-side job sequencer for the QEA core: loads CTX RAM, seeds STATE RAM with |0..0>,
// launches the core, times it, then streams the final state vector out with backpressure.
module qea_host_sequencer #(
  parameter int          PE_NUM_WIDTH            = 2,
  parameter int          PE_NUM                  = 4,
  parameter int          DATA_WIDTH              = 32,
  parameter int          STATE_DATA_WIDTH        = 64,
  parameter int          STATE_ADDR_WIDTH        = 16,
  parameter int          GATE_CONTEXT_DATA_WIDTH = 64,
  parameter int          GATE_CONTEXT_ADDR_WIDTH = 16,
  parameter int          MAX_QBIT_WIDTH          = 6,
  parameter int          NUM_FRAC_BIT            = 30,
  parameter int          READ_LAT                = 1,
  parameter int unsigned TIMEOUT_CYCLES          = 32'd16777216
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               i_go,
  input  logic [MAX_QBIT_WIDTH-1:0]          i_qbit_num,
  input  logic [GATE_CONTEXT_ADDR_WIDTH-1:0] i_ins_num,
  qea_host_sequencer_if.master               bus,
  output logic                               o_busy,
  output logic                               o_done,
  output logic                               o_err,
  output logic [31:0]                        o_cycles
);
  localparam int SW = PE_NUM * STATE_DATA_WIDTH;
  localparam logic [DATA_WIDTH-1:0]     ONE_FX     = DATA_WIDTH'(1) << NUM_FRAC_BIT;
  localparam logic [SW-1:0]             INIT_WORD0 = {ONE_FX, {(SW - DATA_WIDTH){1'b0}}};
  localparam logic [MAX_QBIT_WIDTH-1:0] QBIT_MIN   = MAX_QBIT_WIDTH'(PE_NUM_WIDTH);
  localparam logic [MAX_QBIT_WIDTH-1:0] QBIT_MAX   = MAX_QBIT_WIDTH'(STATE_ADDR_WIDTH + PE_NUM_WIDTH);
  localparam logic [7:0]                LAT_M1     = 8'(READ_LAT - 1);

  typedef enum logic [3:0] {
    S_IDLE, S_LOAD_CTX, S_INIT, S_START, S_RUN,
    S_RD_ISSUE, S_RD_WAIT, S_RD_HOLD, S_DONE
  } state_t;

  state_t                             state_q;
  logic [GATE_CONTEXT_ADDR_WIDTH-1:0] ins_num_q;
  logic [GATE_CONTEXT_ADDR_WIDTH-1:0] ctx_cnt_q;
  logic [STATE_ADDR_WIDTH-1:0]        last_addr_q;
  logic [7:0]                         lat_cnt_q;
  logic                               first_run_q;

  logic                               s_ctx_ready_q;
  logic                               ctx_en_q;
  logic [GATE_CONTEXT_ADDR_WIDTH-1:0] ctx_addr_q;
  logic [GATE_CONTEXT_DATA_WIDTH-1:0] ctx_data_q;
  logic                               state_ena_q;
  logic                               state_wea_q;
  logic [STATE_ADDR_WIDTH-1:0]        state_addr_q;
  logic [SW-1:0]                      state_dina_q;
  logic                               start_q;
  logic                               res_valid_q;
  logic [SW-1:0]                      res_data_q;
  logic                               res_last_q;
  logic                               busy_q;
  logic                               done_q;
  logic                               err_q;
  logic [31:0]                        cycles_q;

  logic                               cfg_ok_d;
  logic [STATE_ADDR_WIDTH:0]          depth_d;
  logic [STATE_ADDR_WIDTH:0]          depth_m1_d;
  logic [STATE_ADDR_WIDTH-1:0]        last_addr_d;
  logic [31:0]                        cycles_inc_d;
  logic                               ctx_hs_d;
  logic                               res_hs_d;

  // Depth is one wider than the address so a full-size job (2**STATE_ADDR_WIDTH words) fits.
  assign cfg_ok_d     = (i_qbit_num > QBIT_MIN) && (i_qbit_num <= QBIT_MAX);
  assign depth_d      = (STATE_ADDR_WIDTH + 1)'(1) << (i_qbit_num - QBIT_MIN);
  assign depth_m1_d   = depth_d - (STATE_ADDR_WIDTH + 1)'(1);
  assign last_addr_d  = depth_m1_d[STATE_ADDR_WIDTH-1:0];
  assign cycles_inc_d = (cycles_q == 32'hFFFF_FFFF) ? cycles_q : cycles_q + 32'd1;
  assign ctx_hs_d     = bus.s_ctx_valid & s_ctx_ready_q;
  assign res_hs_d     = res_valid_q & bus.m_res_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      ins_num_q     <= '0;
      ctx_cnt_q     <= '0;
      last_addr_q   <= '0;
      lat_cnt_q     <= '0;
      first_run_q   <= 1'b0;
      s_ctx_ready_q <= 1'b0;
      ctx_en_q      <= 1'b0;
      ctx_addr_q    <= '0;
      ctx_data_q    <= '0;
      state_ena_q   <= 1'b0;
      state_wea_q   <= 1'b0;
      state_addr_q  <= '0;
      state_dina_q  <= '0;
      start_q       <= 1'b0;
      res_valid_q   <= 1'b0;
      res_data_q    <= '0;
      res_last_q    <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      err_q         <= 1'b0;
      cycles_q      <= '0;
    end else begin
      ctx_en_q <= 1'b0;
      start_q  <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;

      case (state_q)
        S_IDLE: begin
          if (i_go) begin
            if (!cfg_ok_d) begin
              err_q <= 1'b1;
            end else begin
              busy_q      <= 1'b1;
              ins_num_q   <= i_ins_num;
              ctx_cnt_q   <= '0;
              last_addr_q <= last_addr_d;
              if (i_ins_num == '0) begin
                state_q      <= S_INIT;
                state_ena_q  <= 1'b1;
                state_wea_q  <= 1'b1;
                state_addr_q <= '0;
                state_dina_q <= INIT_WORD0;
              end else begin
                state_q       <= S_LOAD_CTX;
                s_ctx_ready_q <= 1'b1;
              end
            end
          end
        end

        S_LOAD_CTX: begin
          if (ctx_hs_d) begin
            ctx_en_q   <= 1'b1;
            ctx_addr_q <= ctx_cnt_q;
            ctx_data_q <= bus.s_ctx_data;
            ctx_cnt_q  <= ctx_cnt_q + 1'b1;
            if (ctx_cnt_q + 1'b1 == ins_num_q) begin
              s_ctx_ready_q <= 1'b0;
              state_q       <= S_INIT;
              state_ena_q   <= 1'b1;
              state_wea_q   <= 1'b1;
              state_addr_q  <= '0;
              state_dina_q  <= INIT_WORD0;
            end
          end
        end

        S_INIT: begin
          if (state_addr_q == last_addr_q) begin
            state_ena_q  <= 1'b0;
            state_wea_q  <= 1'b0;
            state_addr_q <= '0;
            state_dina_q <= '0;
            start_q      <= 1'b1;
            cycles_q     <= '0;
            state_q      <= S_START;
          end else begin
            state_addr_q <= state_addr_q + 1'b1;
            state_dina_q <= '0;
          end
        end

        S_START: begin
          first_run_q <= 1'b1;
          state_q     <= S_RUN;
        end

        // The core may still show the previous job's completion for one cycle after start.
        S_RUN: begin
          first_run_q <= 1'b0;
          cycles_q    <= cycles_inc_d;
          if (bus.i_complete && !first_run_q) begin
            state_q      <= S_RD_ISSUE;
            state_ena_q  <= 1'b1;
            state_wea_q  <= 1'b0;
            state_addr_q <= '0;
          end else if (cycles_inc_d >= TIMEOUT_CYCLES) begin
            err_q   <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end
        end

        S_RD_ISSUE: begin
          state_ena_q <= 1'b0;
          lat_cnt_q   <= '0;
          state_q     <= S_RD_WAIT;
        end

        S_RD_WAIT: begin
          if (lat_cnt_q == LAT_M1) begin
            res_valid_q <= 1'b1;
            res_data_q  <= bus.i_state_dout;
            res_last_q  <= (state_addr_q == last_addr_q);
            state_q     <= S_RD_HOLD;
          end else begin
            lat_cnt_q <= lat_cnt_q + 8'd1;
          end
        end

        // One read in flight at a time: the next address is issued only after acceptance.
        S_RD_HOLD: begin
          if (res_hs_d) begin
            res_valid_q <= 1'b0;
            res_last_q  <= 1'b0;
            if (res_last_q) begin
              done_q  <= 1'b1;
              state_q <= S_DONE;
            end else begin
              state_ena_q  <= 1'b1;
              state_addr_q <= state_addr_q + 1'b1;
              state_q      <= S_RD_ISSUE;
            end
          end
        end

        S_DONE: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end

        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.s_ctx_ready   = s_ctx_ready_q;
  assign bus.o_ctx_en      = ctx_en_q;
  assign bus.o_ctx_wea     = ctx_en_q;
  assign bus.o_ctx_addr    = ctx_addr_q;
  assign bus.o_ctx_data    = ctx_data_q;
  assign bus.o_state_ena   = state_ena_q;
  assign bus.o_state_wea   = state_wea_q;
  assign bus.o_state_addra = state_addr_q;
  assign bus.o_state_dina  = state_dina_q;
  assign bus.o_start       = start_q;
  assign bus.m_res_valid   = res_valid_q;
  assign bus.m_res_data    = res_data_q;
  assign bus.m_res_last    = res_last_q;
  assign o_busy            = busy_q;
  assign o_done            = done_q;
  assign o_err             = err_q;
  assign o_cycles          = cycles_q;
endmodule

// File: tb/tb_qea_host_sequencer.sv
// Bench for qea_host_sequencer: mock STATE RAM + QEA core, random ctx/ready stimulus,
// table-driven jobs checked against per-job expectations derived from the job parameters.
module tb_qea_host_sequencer;
  localparam int TB_TIMEOUT = 3000;
  localparam logic [255:0] INIT0 = {32'h4000_0000, 224'h0};

  typedef struct {
    int qbit;
    int ins;
    bit gap;
    int ready_pct;
    int delay;
    bit exp_err;
    int exp_depth;
    int exp_cycles;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_go = 1'b0;
  logic [5:0]  i_qbit_num = '0;
  logic [15:0] i_ins_num = '0;
  logic        o_busy, o_done, o_err;
  logic [31:0] o_cycles;

  always #5 clk = ~clk;

  qea_host_sequencer_if bus ();

  qea_host_sequencer #(.TIMEOUT_CYCLES(TB_TIMEOUT)) dut (
    .clk(clk), .rst(rst), .i_go(i_go), .i_qbit_num(i_qbit_num), .i_ins_num(i_ins_num),
    .bus(bus), .o_busy(o_busy), .o_done(o_done), .o_err(o_err), .o_cycles(o_cycles)
  );

  int n_checks = 0;
  int n_pass = 0;
  int ready_pct = 100;
  int complete_delay = 0;
  logic [63:0]  ctx_words [0:255];
  logic [255:0] job_vals  [0:255];

  task automatic check_int(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic check_word(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Mock QEA: STATE RAM with 1-cycle registered read; on start the "computed" state replaces
  // the RAM contents and completion is raised complete_delay cycles after the start cycle.
  logic [255:0] mem [0:255];
  int qcnt;
  bit qrun;
  always @(posedge clk) begin
    if (rst) begin
      qrun             <= 1'b0;
      qcnt             <= 0;
      bus.i_complete   <= 1'b0;
      bus.i_state_dout <= '0;
    end else begin
      if (bus.o_state_ena && bus.o_state_wea && bus.o_state_addra < 16'd256)
        mem[bus.o_state_addra[7:0]] <= bus.o_state_dina;
      if (bus.o_state_ena && !bus.o_state_wea)
        bus.i_state_dout <= (bus.o_state_addra < 16'd256) ? mem[bus.o_state_addra[7:0]] : '0;
      if (bus.o_start) begin
        for (int i = 0; i < 256; i++) mem[i] <= job_vals[i];
        qcnt <= 1;
        qrun <= 1'b1;
      end else if (qrun) begin
        qcnt <= qcnt + 1;
        if (qcnt + 1 == complete_delay) begin
          bus.i_complete <= 1'b1;
          qrun           <= 1'b0;
        end else begin
          bus.i_complete <= 1'b0;
        end
      end
    end
  end

  initial begin
    bus.m_res_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      bus.m_res_ready = ($urandom_range(99) < ready_pct);
    end
  end

  // Observation side, sampled on the falling edge.
  logic [15:0]  ctx_addr_log [$];
  logic [63:0]  ctx_data_log [$];
  logic [15:0]  init_addr_log [$];
  logic [255:0] init_data_log [$];
  logic [255:0] res_data_log [$];
  bit           res_last_log [$];
  int start_cnt = 0, err_cnt = 0, done_cnt = 0, ena_cnt = 0, proto_bad = 0;
  bit hold_pend = 1'b0;
  logic [255:0] hold_data;

  always @(negedge clk) begin
    if (rst) begin
      hold_pend <= 1'b0;
    end else begin
      if (bus.o_ctx_en != bus.o_ctx_wea) proto_bad <= proto_bad + 1;
      if (bus.o_ctx_en) begin
        ctx_addr_log.push_back(bus.o_ctx_addr);
        ctx_data_log.push_back(bus.o_ctx_data);
      end
      if (bus.o_state_ena) ena_cnt <= ena_cnt + 1;
      if (bus.o_state_ena && bus.o_state_wea) begin
        init_addr_log.push_back(bus.o_state_addra);
        init_data_log.push_back(bus.o_state_dina);
      end
      if (bus.o_start) start_cnt <= start_cnt + 1;
      if (o_err) err_cnt <= err_cnt + 1;
      if (o_done) done_cnt <= done_cnt + 1;
      if (hold_pend && (!bus.m_res_valid || bus.m_res_data !== hold_data)) proto_bad <= proto_bad + 1;
      if (bus.m_res_valid) begin
        if (bus.m_res_ready) begin
          res_data_log.push_back(bus.m_res_data);
          res_last_log.push_back(bus.m_res_last);
          hold_pend <= 1'b0;
        end else begin
          hold_pend <= 1'b1;
          hold_data <= bus.m_res_data;
        end
      end
    end
  end

  function automatic bit any_output();
    return bus.s_ctx_ready | bus.o_ctx_en | bus.o_ctx_wea | (|bus.o_ctx_addr) | (|bus.o_ctx_data) |
           bus.o_state_ena | bus.o_state_wea | (|bus.o_state_addra) | (|bus.o_state_dina) |
           bus.o_start | bus.m_res_valid | (|bus.m_res_data) | bus.m_res_last |
           o_busy | o_done | o_err | (|o_cycles);
  endfunction

  task automatic drive_ctx(input int n, input bit gap);
    int k = 0;
    int cyc = 0;
    while (k < n && cyc < 30000) begin
      bus.s_ctx_valid = gap ? 1'($urandom_range(1)) : 1'b1;
      bus.s_ctx_data  = ctx_words[k];
      @(negedge clk);
      if (bus.s_ctx_valid && bus.s_ctx_ready) k++;
      @(posedge clk);
      #1;
      cyc++;
    end
    bus.s_ctx_valid = 1'b0;
  endtask

  task automatic randomize_job();
    for (int i = 0; i < 256; i++) begin
      ctx_words[i] = {$urandom, $urandom};
      job_vals[i]  = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    end
  endtask

  task automatic pulse_go(input int qbit, input int ins);
    i_qbit_num = 6'(qbit);
    i_ins_num  = 16'(ins);
    i_go       = 1'b1;
    @(posedge clk);
    #1;
    i_go = 1'b0;
  endtask

  task automatic run_job(input vec_t v);
    int ctx_b, init_b, res_b, start0, err0, done0, ena0, proto0, bad, n, exp_res;
    randomize_job();
    ctx_b  = ctx_addr_log.size();
    init_b = init_addr_log.size();
    res_b  = res_data_log.size();
    start0 = start_cnt; err0 = err_cnt; done0 = done_cnt; ena0 = ena_cnt; proto0 = proto_bad;
    complete_delay = v.delay;
    ready_pct      = v.ready_pct;
    exp_res        = v.exp_err ? 0 : v.exp_depth;
    pulse_go(v.qbit, v.ins);
    fork
      drive_ctx(v.ins, v.gap);
      for (int cyc = 0; cyc < 30000 && done_cnt == done0 && err_cnt == err0; cyc++) @(negedge clk);
    join
    repeat (3) @(negedge clk);

    check_int("busy_after_job", int'(o_busy), 0);
    check_int("err_pulses", err_cnt - err0, int'(v.exp_err));
    check_int("done_pulses", done_cnt - done0, v.exp_err ? 0 : 1);

    n = ctx_addr_log.size() - ctx_b;
    check_int("ctx_write_count", n, v.ins);
    bad = 0;
    for (int i = 0; i < n && i < 256; i++)
      if (ctx_addr_log[ctx_b + i] != 16'(i) || ctx_data_log[ctx_b + i] !== ctx_words[i]) bad++;
    check_int("ctx_write_content_bad", bad, 0);

    n = init_addr_log.size() - init_b;
    check_int("init_write_count", n, v.exp_depth);
    bad = 0;
    for (int i = 0; i < n && i < 256; i++)
      if (init_addr_log[init_b + i] != 16'(i) || init_data_log[init_b + i] !== ((i == 0) ? INIT0 : 256'h0)) bad++;
    check_int("init_write_content_bad", bad, 0);

    check_int("start_pulses", start_cnt - start0, (v.exp_depth > 0) ? 1 : 0);
    if (v.exp_depth > 0) check_int("o_cycles", int'(o_cycles), v.exp_cycles);
    check_int("state_ena_cycles", ena_cnt - ena0, v.exp_depth + exp_res);

    n = res_data_log.size() - res_b;
    check_int("result_count", n, exp_res);
    bad = 0;
    for (int i = 0; i < n && i < 256; i++)
      if (res_data_log[res_b + i] !== job_vals[i] || res_last_log[res_b + i] != (i == exp_res - 1)) bad++;
    check_int("result_content_bad", bad, 0);
    check_int("protocol_violations", proto_bad - proto0, 0);

    $display("job qbit=%0d ins=%0d gap=%0d ready_pct=%0d cycles=%0d results=%0d err=%0d done=%0d",
             v.qbit, v.ins, v.gap, v.ready_pct, o_cycles, n, err_cnt - err0, done_cnt - done0);
  endtask

  vec_t vecs [7];
  vec_t v_after_rst;

  initial begin
    int ena0, ctx0, start0;
    bit hit;
    //          qbit ins gap rdy% delay err depth cycles
    vecs[0] = '{9,  125, 0, 100, 1000, 0, 128, 1000};
    vecs[1] = '{9,  125, 1,  30, 1000, 0, 128, 1000};
    vecs[2] = '{2,    0, 0, 100,    0, 1,   0,    0};
    vecs[3] = '{19,   0, 0, 100,    0, 1,   0,    0};
    vecs[4] = '{3,    0, 0,  60,   50, 0,   2,   50};
    vecs[5] = '{4,    3, 1, 100,    0, 1,   4, TB_TIMEOUT};
    vecs[6] = '{10,   8, 0,  50,   20, 0, 256,   20};
    v_after_rst = '{5, 6, 1, 70, 40, 0, 8, 40};

    bus.s_ctx_valid = 1'b0;
    bus.s_ctx_data  = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_int("reset_outputs_zero", int'(any_output()), 0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    for (int j = 0; j < 7; j++) run_job(vecs[j]);

    // Reset in the middle of INIT, then a fresh job must start over from ctx address 0.
    randomize_job();
    complete_delay = 1000;
    ready_pct      = 100;
    @(posedge clk);
    #1;
    pulse_go(9, 2);
    hit = 1'b0;
    fork
      drive_ctx(2, 1'b0);
      for (int cyc = 0; cyc < 5000 && !hit; cyc++) begin
        @(negedge clk);
        hit = bus.o_state_ena && bus.o_state_wea && bus.o_state_addra == 16'd40;
      end
    join
    check_int("reached_init_addr40", int'(hit), 1);
    rst = 1'b1;
    @(negedge clk);
    check_int("midjob_reset_outputs_zero", int'(any_output()), 0);
    rst = 1'b0;
    ena0 = ena_cnt; ctx0 = ctx_addr_log.size(); start0 = start_cnt;
    repeat (20) @(negedge clk);
    check_int("no_activity_after_reset", (ena_cnt - ena0) + (ctx_addr_log.size() - ctx0) + (start_cnt - start0), 0);
    $display("reset during INIT at addr 40: outputs cleared, bus quiet");
    @(posedge clk);
    #1;
    run_job(v_after_rst);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, checks passed %0d of %0d", n_pass, n_checks);
    $fatal(1, "watchdog");
  end
endmodule
